packet_rr_arbiter: RTL

Round-robin arbiter that shares one multi-lane output bus among `N_REQ` requesters. Each requester sends fixed-length packets of `N_BEAT` beats, and each beat carries `N_LANE` lanes of `DW` bits. A grant is locked for a whole packet so beats from different sources never interleave. The block sits between the per-source stimulus arrays and the shared consumer array in the simulation datapath, and keeps per-source packet counters for checking by the cosim bench.

---
 rtl/packet_rr_arbiter_if.sv | 29 ++
 rtl/packet_rr_arbiter.sv | 92 +++++++++
 2 files changed

// File: rtl/packet_rr_arbiter_if.sv
// Bus bundle for the packet round-robin arbiter: per-requester inputs, shared output bus, packet counters.
// The master modport is the arbiter side. The slave modport is the requester/consumer side.
interface packet_rr_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int N_LANE = 4,
  parameter int DW     = 11,
  parameter int CNT_W  = 4,
  parameter int SW     = $clog2(N_REQ)
);
  logic [N_REQ-1:0]                      req_valid;
  logic [N_REQ-1:0]                      req_ready;
  logic [N_REQ-1:0][N_LANE-1:0][DW-1:0]  req_data;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [N_LANE-1:0][DW-1:0]             out_data;
  logic [SW-1:0]                         out_src;
  logic                                  out_last;
  logic [N_REQ-1:0][CNT_W-1:0]           pkt_cnt;

  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src, out_last, pkt_cnt
  );

  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src, out_last, pkt_cnt
  );
endinterface

// File: rtl/packet_rr_arbiter.sv
// Round-robin arbiter that locks one requester onto the shared bus for a whole N_BEAT packet.
// It also keeps a wrapping count of completed packets for each source.
//
// state | meaning
// IDLE  | no packet owns the bus; pick the next requester starting at ptr
// BUSY  | grant owns the bus until its last beat is accepted
module packet_rr_arbiter #(
  parameter int N_REQ  = 3,
  parameter int N_BEAT = 2,
  parameter int N_LANE = 4,
  parameter int DW     = 11,
  parameter int CNT_W  = 4,
  localparam int SW    = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  packet_rr_arbiter_if.master bus
);
  localparam int BW  = (N_BEAT > 1) ? $clog2(N_BEAT) : 1;
  localparam int SW1 = SW + 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(N_BEAT - 1);
  localparam logic [SW-1:0] SRC_LAST  = SW'(N_REQ - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                      state;
  logic [SW-1:0]               ptr;
  logic [SW-1:0]               grant;
  logic [SW-1:0]               pick;
  logic [BW-1:0]               beat;
  logic [N_REQ-1:0][CNT_W-1:0] cnt;

  // Scan from the highest rotation offset down so the lowest offset from ptr wins.
  always_comb begin
    logic [SW1-1:0] cand;
    cand = '0;
    pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + SW1'(k);
      if (cand >= SW1'(N_REQ)) cand = cand - SW1'(N_REQ);
      if (bus.req_valid[cand[SW-1:0]]) pick = cand[SW-1:0];
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    if (state == BUSY) begin
      bus.req_ready[grant] = bus.out_ready;
      bus.out_valid        = bus.req_valid[grant];
      bus.out_last         = (beat == BEAT_LAST);
      bus.out_data         = bus.req_data[grant];
    end
  end

  assign bus.out_src = grant;
  assign bus.pkt_cnt = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      grant <= '0;
      beat  <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            grant <= pick;
            beat  <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.out_valid && bus.out_ready) begin
            if (beat == BEAT_LAST) begin
              cnt[grant] <= cnt[grant] + CNT_W'(1);
              ptr        <= (grant == SRC_LAST) ? '0 : grant + SW'(1);
              state      <= IDLE;
            end else begin
              beat <= beat + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
